// File: rtl/shiftreg_pkg.sv
// Shared types for the serial shift-register transmitter/receiver pair.
package shiftreg_pkg;

    typedef enum logic {
        DIR_LSB_FIRST = 1'b0,
        DIR_MSB_FIRST = 1'b1
    } shift_dir_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } piso_state_e;

endpackage

// File: rtl/shiftreg_piso_tx.sv
// Parallel-in/serial-out transmitter: serializes N-bit words onto dout/sh_en_o/dir_o
// with a one-entry hold buffer so back-to-back words go out without a bubble.
module shiftreg_piso_tx
    import shiftreg_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    input  logic         load_dir,
    input  logic         tx_en,
    output logic         dout,
    output logic         sh_en_o,
    output logic         dir_o,
    output logic         last,
    output logic         busy
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    piso_state_e      state_q, state_d;
    logic [N-1:0]     shreg_q, shreg_d;
    shift_dir_e       dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     hold_q, hold_d;
    shift_dir_e       hold_dir_q, hold_dir_d;
    logic             hold_full_q, hold_full_d;

    logic accept_c;
    logic at_last_c;

    assign load_ready = !hold_full_q;
    assign accept_c   = load_valid && !hold_full_q;
    assign at_last_c  = (cnt_q == CNT_LAST);

    // Next-state and serial-output logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_dir_d  = hold_dir_q;
        hold_full_d = hold_full_q;
        dout        = 1'b0;
        sh_en_o     = 1'b0;
        dir_o       = 1'b0;
        last        = 1'b0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    shreg_d = load_data;
                    dir_d   = shift_dir_e'(load_dir);
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                dout    = (dir_q == DIR_MSB_FIRST) ? shreg_q[N-1] : shreg_q[0];
                dir_o   = dir_q;
                sh_en_o = tx_en;
                last    = at_last_c;
                busy    = 1'b1;

                if (tx_en) begin
                    shreg_d = (dir_q == DIR_MSB_FIRST) ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + CNT_W'(1);
                end

                // Final-bit edge: the held word wins over a same-cycle load
                if (at_last_c && tx_en) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        dir_d       = hold_dir_q;
                        hold_full_d = 1'b0;
                    end else if (accept_c) begin
                        shreg_d = load_data;
                        dir_d   = shift_dir_e'(load_dir);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept_c) begin
                    hold_d      = load_data;
                    hold_dir_d  = shift_dir_e'(load_dir);
                    hold_full_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            dir_q       <= DIR_LSB_FIRST;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_dir_q  <= DIR_LSB_FIRST;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_dir_q  <= hold_dir_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_shiftreg_piso_tx.sv
// Bench for shiftreg_piso_tx: directed scenarios plus random traffic against a
// word-queue reference model and a behavioural receiver on the serial lines.
module tb_shiftreg_piso_tx;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;
    logic         load_dir;
    logic         tx_en;
    logic         dout;
    logic         sh_en_o;
    logic         dir_o;
    logic         last;
    logic         busy;

    shiftreg_piso_tx #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .tx_en      (tx_en),
        .dout       (dout),
        .sh_en_o    (sh_en_o),
        .dir_o      (dir_o),
        .last       (last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         dir;
    } word_t;

    // Reference: queue of accepted words (in flight + held) and bit index of the head
    word_t        mq[$];
    int           mk;
    // Receiver model
    logic [N-1:0] rx_q;
    int           rx_cnt;
    logic [N-1:0] rx_last;
    int           n_tests;
    int           n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs_now();
        return {dout, sh_en_o, dir_o, last, busy, load_ready};
    endfunction

    function automatic logic [5:0] model_outs(input logic te);
        logic b;
        if (mq.size() == 0) return 6'b000001;
        if (mq[0].dir) b = mq[0].data[N-1-mk];
        else           b = mq[0].data[mk];
        return {b, te, mq[0].dir, 1'(mk == N - 1), 1'b1, 1'(mq.size() < 2)};
    endfunction

    task automatic model_reset();
        mq.delete();
        mk     = 0;
        rx_q   = '0;
        rx_cnt = 0;
    endtask

    // One clock: drive inputs, check outputs and receiver, advance the model
    task automatic cycle(input logic v, input logic [N-1:0] d, input logic dr, input logic te);
        logic  acc;
        word_t w;
        load_valid = v;
        load_data  = d;
        load_dir   = dr;
        tx_en      = te;
        #1;
        chk("outs", 32'(outs_now()), 32'(model_outs(te)));
        if (sh_en_o) begin
            rx_q = dir_o ? {rx_q[N-2:0], dout} : {dout, rx_q[N-1:1]};
            rx_cnt++;
            if (rx_cnt == N) begin
                rx_cnt  = 0;
                rx_last = rx_q;
                if (mq.size() > 0) chk("rx_word", 32'(rx_q), 32'(mq[0].data));
                else               chk("rx_word_unexpected", 32'(1), 32'(0));
            end
        end
        acc = v && (mq.size() < 2);
        @(posedge clk);
        #1;
        if (mq.size() > 0 && te) begin
            mk++;
            if (mk == N) begin
                mk = 0;
                void'(mq.pop_front());
            end
        end
        if (acc) begin
            w.data = d;
            w.dir  = dr;
            mq.push_back(w);
        end
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int guard;
        n_tests    = 0;
        n_fail     = 0;
        rx_last    = '0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_dir   = 1'b0;
        tx_en      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs_now()), 32'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MSB-first C5
        cycle(1'b1, 8'hC5, 1'b1, 1'b1);
        run_idle(8);
        chk("msb_rx", 32'(rx_last), 32'hC5);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // LSB-first C5
        cycle(1'b1, 8'hC5, 1'b0, 1'b1);
        run_idle(9);
        chk("lsb_rx", 32'(rx_last), 32'hC5);

        // Back-to-back via hold: second word offered during bit 2
        cycle(1'b1, 8'h12, 1'b1, 1'b1);
        run_idle(2);
        cycle(1'b1, 8'h34, 1'b1, 1'b1);
        chk("b2b_ready_low", 32'(load_ready), 32'(0));
        run_idle(13);
        chk("b2b_rx", 32'(rx_last), 32'h34);
        run_idle(1);

        // Direct reload on the final bit
        cycle(1'b1, 8'hE1, 1'b0, 1'b1);
        run_idle(7);
        cycle(1'b1, 8'hF0, 1'b1, 1'b1);
        chk("reload_busy", 32'(busy), 32'(1));
        run_idle(8);
        chk("reload_rx", 32'(rx_last), 32'hF0);
        run_idle(1);

        // Stall after bit 3
        cycle(1'b1, 8'hA5, 1'b1, 1'b1);
        run_idle(3);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        run_idle(5);
        chk("stall_rx", 32'(rx_last), 32'hA5);
        run_idle(1);

        // Reset mid-word with a held word
        cycle(1'b1, 8'h3C, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        run_idle(2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", 32'(outs_now()), 32'h01);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b1);
        run_idle(8);
        chk("post_rst_rx", 32'(rx_last), 32'h5A);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'(($urandom % 10) < 4), N'($urandom), 1'($urandom), 1'(($urandom % 4) != 0));
        end
        guard = 0;
        while (mq.size() != 0 && guard < 100) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            guard++;
        end
        chk("drain_timeout", 32'(guard >= 100), 32'(0));
        chk("drain_idle", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
